// File: rtl/fwd_select_gen.sv
// Operand-forwarding select generator with load-use stall detection.
// Tracks EX/MEM destinations internally and registers per-source selects into EX.
module fwd_select_gen #(
  parameter int unsigned REG_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [REG_ADDR_BITS-1:0] id_rs,
  input  logic [REG_ADDR_BITS-1:0] id_rt,
  input  logic                     id_uses_rs,
  input  logic                     id_uses_rt,
  input  logic [REG_ADDR_BITS-1:0] id_dst,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     flush,
  output logic                     stall,
  output logic [1:0]               ex_sel_a,
  output logic [1:0]               ex_sel_b
);

  typedef enum logic [1:0] {
    SEL_RF    = 2'b00,
    SEL_EXMEM = 2'b01,
    SEL_MEMWB = 2'b10
  } fwd_sel_e;

  logic                     ex_v_q,   ex_v_d;
  logic [REG_ADDR_BITS-1:0] ex_dst_q, ex_dst_d;
  logic                     ex_wr_q,  ex_wr_d;
  logic                     ex_ld_q,  ex_ld_d;
  logic                     mem_v_q,  mem_v_d;
  logic [REG_ADDR_BITS-1:0] mem_dst_q, mem_dst_d;
  logic                     mem_wr_q, mem_wr_d;
  fwd_sel_e                 sel_a_q, sel_a_d;
  fwd_sel_e                 sel_b_q, sel_b_d;

  logic ex_prod_rs, ex_prod_rt, mem_prod_rs, mem_prod_rt;
  logic load_hazard, load_ex;

  always_comb begin
    ex_prod_rs  = ex_v_q  && ex_wr_q  && (ex_dst_q  == id_rs) && (id_rs != '0);
    ex_prod_rt  = ex_v_q  && ex_wr_q  && (ex_dst_q  == id_rt) && (id_rt != '0);
    mem_prod_rs = mem_v_q && mem_wr_q && (mem_dst_q == id_rs) && (id_rs != '0);
    mem_prod_rt = mem_v_q && mem_wr_q && (mem_dst_q == id_rt) && (id_rt != '0);
  end

  always_comb begin
    load_hazard = ex_v_q && ex_ld_q && (ex_dst_q != '0) &&
                  ((id_uses_rs && (id_rs == ex_dst_q)) ||
                   (id_uses_rt && (id_rt == ex_dst_q)));
    stall   = id_valid && !flush && load_hazard;
    load_ex = id_valid && !flush && !stall;
  end

  // Bubbles (stall, flush, invalid) carry 00 selects; EX producer beats MEM producer.
  always_comb begin
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    if (load_ex && id_uses_rs) begin
      if (ex_prod_rs)       sel_a_d = SEL_EXMEM;
      else if (mem_prod_rs) sel_a_d = SEL_MEMWB;
    end
    if (load_ex && id_uses_rt) begin
      if (ex_prod_rt)       sel_b_d = SEL_EXMEM;
      else if (mem_prod_rt) sel_b_d = SEL_MEMWB;
    end
  end

  always_comb begin
    mem_v_d   = ex_v_q;
    mem_dst_d = ex_dst_q;
    mem_wr_d  = ex_wr_q;
    ex_v_d    = load_ex;
    ex_dst_d  = id_dst;
    ex_wr_d   = id_reg_write;
    ex_ld_d   = id_mem_read;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q    <= 1'b0;
      ex_dst_q  <= '0;
      ex_wr_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_v_q   <= 1'b0;
      mem_dst_q <= '0;
      mem_wr_q  <= 1'b0;
      sel_a_q   <= SEL_RF;
      sel_b_q   <= SEL_RF;
    end else begin
      ex_v_q    <= ex_v_d;
      ex_dst_q  <= ex_dst_d;
      ex_wr_q   <= ex_wr_d;
      ex_ld_q   <= ex_ld_d;
      mem_v_q   <= mem_v_d;
      mem_dst_q <= mem_dst_d;
      mem_wr_q  <= mem_wr_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign ex_sel_a = sel_a_q;
  assign ex_sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_select_gen.sv
// Bench for fwd_select_gen: directed hazard scenarios then random instruction
// streams, compared against a two-deep in-flight history model.
module tb_fwd_select_gen;

  localparam int unsigned RB = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, flush;
  logic [RB-1:0] id_rs, id_rt, id_dst;
  logic          stall;
  logic [1:0]    ex_sel_a, ex_sel_b;

  int n_checks = 0;
  int n_errors = 0;

  fwd_select_gen #(.REG_ADDR_BITS(RB)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall), .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit [RB-1:0] dst;
    bit          wr;
    bit          ld;
  } instr_t;

  // hist[0] = instruction now in EX, hist[1] = instruction now in MEM
  instr_t hist[2];
  int     exp_a, exp_b;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) hist[i] = '{v: 0, dst: 0, wr: 0, ld: 0};
    exp_a = 0;
    exp_b = 0;
  endfunction

  function automatic int model_stall();
    if (!id_valid || flush || !hist[0].v || !hist[0].ld || hist[0].dst == 0) return 0;
    if (id_uses_rs && id_rs == hist[0].dst) return 1;
    if (id_uses_rt && id_rt == hist[0].dst) return 1;
    return 0;
  endfunction

  // Youngest in-flight writer of r decides the code: age 0 -> 1, age 1 -> 2.
  function automatic int model_sel(input bit used, input bit [RB-1:0] r);
    if (!used || r == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (hist[age].v && hist[age].wr && hist[age].dst == r) return age + 1;
    return 0;
  endfunction

  function automatic void model_clock(input int stl);
    bit issue;
    issue = id_valid && !flush && (stl == 0);
    exp_a = issue ? model_sel(id_uses_rs, id_rs) : 0;
    exp_b = issue ? model_sel(id_uses_rt, id_rt) : 0;
    hist[1] = hist[0];
    hist[0] = '{v: issue, dst: id_dst, wr: id_reg_write, ld: id_mem_read};
  endfunction

  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input int dst, input bit wr, input bit ld, input bit fl);
    id_valid = v;  id_rs = RB'(rs); id_uses_rs = urs; id_rt = RB'(rt); id_uses_rt = urt;
    id_dst = RB'(dst); id_reg_write = wr; id_mem_read = ld; flush = fl;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step(input string tag, output int stl);
    #1;
    stl = model_stall();
    check({tag, ".stall"}, int'(stall), stl);
    @(posedge clk);
    model_clock(stl);
    #1;
    check({tag, ".sel_a"}, int'(ex_sel_a), exp_a);
    check({tag, ".sel_b"}, int'(ex_sel_b), exp_b);
    @(negedge clk);
  endtask

  task automatic nop_step(input string tag);
    int s;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(tag, s);
  endtask

  initial begin
    int s;
    int held;
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst.stall", int'(stall), 0);
    check("rst.sel_a", int'(ex_sel_a), 0);
    check("rst.sel_b", int'(ex_sel_b), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // 1: EX/MEM forward on rs
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); step("t1.prod", s);
    set_id(1, 3, 1, 1, 1, 4, 1, 0, 0); step("t1.cons", s);
    check("t1.a01", int'(ex_sel_a), 1);
    nop_step("t1.d0"); nop_step("t1.d1");

    // 2: MEM/WB forward on rt
    set_id(1, 1, 1, 2, 1, 5, 1, 0, 0); step("t2.prod", s);
    set_id(1, 1, 1, 2, 1, 9, 1, 0, 0); step("t2.ind", s);
    set_id(1, 8, 1, 5, 1, 10, 1, 0, 0); step("t2.cons", s);
    check("t2.b10", int'(ex_sel_b), 2);
    nop_step("t2.d0"); nop_step("t2.d1");

    // 3: two writers of r6, youngest wins
    set_id(1, 1, 1, 2, 1, 6, 1, 0, 0); step("t3.p0", s);
    set_id(1, 1, 1, 2, 1, 6, 1, 0, 0); step("t3.p1", s);
    set_id(1, 6, 1, 2, 0, 11, 1, 0, 0); step("t3.cons", s);
    check("t3.a01", int'(ex_sel_a), 1);
    nop_step("t3.d0"); nop_step("t3.d1");

    // 4: load-use stall for exactly one cycle
    set_id(1, 1, 1, 0, 0, 7, 1, 1, 0); step("t4.lw", s);
    set_id(1, 7, 1, 2, 1, 12, 1, 0, 0); step("t4.stl", s);
    check("t4.stall1", s, 1);
    step("t4.held", s);
    check("t4.nostall", s, 0);
    check("t4.a10", int'(ex_sel_a), 2);
    nop_step("t4.d0"); nop_step("t4.d1");

    // 5: r0 never forwarded, lw r0 never stalls
    set_id(1, 1, 1, 2, 1, 0, 1, 0, 0); step("t5.p0", s);
    set_id(1, 0, 1, 0, 1, 13, 1, 0, 0); step("t5.c0", s);
    check("t5.a00", int'(ex_sel_a), 0);
    set_id(1, 1, 1, 2, 1, 0, 1, 1, 0); step("t5.lw0", s);
    set_id(1, 0, 1, 0, 1, 14, 1, 0, 0); step("t5.c1", s);
    check("t5.nostall", s, 0);
    nop_step("t5.d0"); nop_step("t5.d1");

    // flush beats a matching load; EX gets a bubble
    set_id(1, 1, 1, 0, 0, 7, 1, 1, 0); step("fl.lw", s);
    set_id(1, 7, 1, 7, 1, 15, 1, 0, 1); step("fl.cons", s);
    check("fl.a00", int'(ex_sel_a), 0);
    set_id(1, 15, 1, 0, 0, 16, 1, 0, 0); step("fl.after", s);
    check("fl.bubble", int'(ex_sel_a), 0);
    nop_step("fl.d0"); nop_step("fl.d1");

    // 6: reset during a load-use stall
    set_id(1, 1, 1, 2, 1, 2, 1, 0, 0); step("t6.p", s);
    set_id(1, 2, 1, 0, 0, 7, 1, 1, 0); step("t6.lw", s);
    check("t6.lw_a01", int'(ex_sel_a), 1);
    set_id(1, 7, 1, 3, 1, 17, 1, 0, 0);
    #1;
    check("t6.pre_stall", int'(stall), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6.rst_stall", int'(stall), 0);
    check("t6.rst_a", int'(ex_sel_a), 0);
    check("t6.rst_b", int'(ex_sel_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1, 7, 1, 2, 1, 18, 1, 0, 0); step("t6.post", s);
    check("t6.post_a", int'(ex_sel_a), 0);
    check("t6.post_b", int'(ex_sel_b), 0);

    // random streams over a small register window to provoke hazards
    held = 0;
    for (int i = 0; i < 600; i++) begin
      if (held == 0) begin
        set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
               $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 1'b0);
      end
      flush = ($urandom_range(0, 9) == 0);
      if (i % 97 == 50) begin
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rnd.rst_stall", int'(stall), 0);
        check("rnd.rst_sel", int'({ex_sel_a, ex_sel_b}), 0);
        rst_n = 1'b1;
        #1;
      end
      step("rnd", s);
      held = s;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
